traffic_phase_fsm: RTL
======================

# traffic_phase_fsm

Intersection phase sequencer that consumes the debounced pedestrian push-button level and drives the north–south (NS) and east–west (EW) lamp heads plus the walk signal. It sits directly downstream of the button debouncer. It contains:
- a one-second tick prescaler;
- a per-phase seconds timer;
- a pedestrian request latch;
- a six-state phase machine.

A pedestrian request shortens NS green once a minimum green time has elapsed, and the walk signal is granted during EW green.

## Interface
- TICK_DIV, 50000000: clock cycles per one-second tick; must be ≥2; prescaler width is $clog2(TICK_DIV).
- T_GREEN, 10: NS and EW green duration in ticks (≥1).
- T_MIN_GREEN, 4: minimum NS green in ticks before a request may end it (1..T_GREEN).
- T_YELLOW, 3: yellow duration in ticks (≥1).
- T_ALLRED, 1: all-red clearance in ticks (≥1).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ped_btn  in  1  clean pedestrian button level from the debouncer; synchronous to clk.
- ns_light  out  3  NS lamp, one-hot {red, yellow, green}.
- ew_light  out  3  EW lamp, one-hot {red, yellow, green}.
- walk  out  1  pedestrian walk lamp.
- ped_pending  out  1  latched, unserved pedestrian request.

## Operation
- **States and lamps:**
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - RED_A: ns=100, ew=100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - RED_B: ns=100, ew=100.
- **Sequence:** NS_GREEN→NS_YELLOW→RED_A→EW_GREEN→EW_YELLOW→RED_B→NS_GREEN.
- **Timed exits:** each state exits when its seconds count reaches its duration:
  - NS_GREEN and EW_GREEN use T_GREEN.
  - Yellows use T_YELLOW.
  - Reds use T_ALLRED.
- **Early NS exit:** in NS_GREEN, if ped_pending=1 and the seconds count ≥ T_MIN_GREEN, exit on that tick.
- **Edge detect:**
  - ped_q registers ped_btn.
  - A rising edge (ped_btn & ~ped_q) sets ped_pending.
  - ped_q resets to 1, so a button held through reset does not generate a request.
- **Request service:** on the cycle the machine enters EW_GREEN, ped_pending is cleared and the served flag is set to its pre-clear value.
- **Walk:** walk = served & (state==EW_GREEN).
- **Simultaneous set/clear:** a rising edge on the same cycle as the EW_GREEN entry clear wins. ped_pending stays 1 and is served in the next cycle.
- **Repeat presses:** additional edges while ped_pending=1 have no effect, and no count is kept.
- **Outputs:** all outputs are registered, or decoded from registered state with no input-to-output combinational path.

## Timing
- **Reset values:**
  - state=NS_GREEN, so ns_light=001 and ew_light=100.
  - walk=0, ped_pending=0, ped_q=1.
  - Prescaler and seconds count are 0.
- **Prescaler:**
  - Counts 0..TICK_DIV-1.
  - tick is asserted for one cycle when the count equals TICK_DIV-1, then wraps to 0.
- **Seconds count:** increments on tick and saturates at 255 (8 bits).
- **Phase restart:** on every state transition, both the prescaler and the seconds count restart at 0.
- **Phase durations:**
  - A timed phase lasts exactly duration×TICK_DIV cycles.
  - An early NS exit occurs exactly T_MIN_GREEN×TICK_DIV cycles after NS_GREEN entry if the request was already pending.
  - Otherwise the early exit occurs on the first tick after the request.
- **Edge to ped_pending:** latency is 1 cycle; ped_pending is high on the cycle after ped_btn first reads 1.
- **Lamp change:** outputs change on the clock edge that changes state, with zero added latency.
- **Mid-operation reset:** asynchronous reset asserted in any state forces the reset values immediately, without waiting for clk. Operation resumes in NS_GREEN on the first clk after release.

## Configuration
- **Macro:** PED_SHORTEN_EN.
- **Defined:** the early NS_GREEN exit on ped_pending is active, as described above.
- **Undefined:**
  - NS_GREEN always lasts T_GREEN ticks.
  - Requests are still latched and served, and walk is still granted in EW_GREEN.
  - T_MIN_GREEN is unused.

## Test plan
Bench parameters: TICK_DIV=4, T_GREEN=6, T_MIN_GREEN=2, T_YELLOW=2, T_ALLRED=1.
- **Free-run:** hold reset low 3 cycles, release with ped_btn=0 → NS green 24 cycles, NS yellow 8, red 4, EW green 24, EW yellow 8, red 4, then back to NS green; walk stays 0 throughout.
- **Early exit:** pulse ped_btn high 3 cycles at cycle 2 of NS_GREEN → ped_pending=1 at cycle 3; NS_YELLOW is entered at cycle 8. In EW_GREEN, walk=1 for 24 cycles and ped_pending=0.
- **Late press:** press at cycle 14 of NS_GREEN → NS_YELLOW entered at cycle 16, on the next tick.
- **Button held through reset:** ped_btn=1 across reset release → ped_pending stays 0 and no early exit occurs. Releasing and pressing again sets ped_pending.
- **Simultaneous set/clear:** rising edge on the EW_GREEN entry cycle → ped_pending=1 one cycle longer, then 0, and walk=1.
- **Macro undefined:** repeat the early-exit stimulus → NS_GREEN lasts the full 24 cycles and walk=1 in the following EW_GREEN.

Source files
------------

// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm: six-phase intersection sequencer with one-second prescaler, per-phase seconds timer and pedestrian request latch.
// Ports: clk (rising edge), reset (async, active-low), ped_btn (debounced button level, clk-synchronous),
//        ns_light/ew_light (one-hot {red,yellow,green}), walk (walk lamp), ped_pending (latched unserved request).
// Build option: define PED_SHORTEN_EN to let a pending request end NS green once T_MIN_GREEN ticks have elapsed.
module traffic_phase_fsm #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned T_GREEN     = 10,
  parameter int unsigned T_MIN_GREEN = 4,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_btn,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending
);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [8:0] GRN = 9'(T_GREEN);
  localparam logic [8:0] YEL = 9'(T_YELLOW);
  localparam logic [8:0] RED = 9'(T_ALLRED);
`ifdef PED_SHORTEN_EN
  localparam logic [8:0] MIN = 9'(T_MIN_GREEN);
`endif
  localparam logic [2:0] NS_G = 3'd0;
  localparam logic [2:0] NS_Y = 3'd1;
  localparam logic [2:0] RED_A = 3'd2;
  localparam logic [2:0] EW_G = 3'd3;
  localparam logic [2:0] EW_Y = 3'd4;
  localparam logic [2:0] RED_B = 3'd5;
  if (TICK_DIV < 2 || T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1 ||
      T_MIN_GREEN < 1 || T_MIN_GREEN > T_GREEN) begin : g_bad_cfg
    $error("traffic_phase_fsm: illegal timing parameters");
  end
  logic [2:0] state_q, state_d, nxt;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0] sec_q, sec_d;
  logic [8:0] sec_nx, dur;
  logic ped_q, pend_q, pend_d, served_q, served_d, def_q, def_d;
  logic tick, early, done, rise, enter, svc;
  always_comb begin
    tick = pre_q == PMAX;
    // one wider than the counter so the compare still works at saturation
    sec_nx = {1'b0, sec_q} + 9'd1;
    dur = (state_q == NS_G || state_q == EW_G) ? GRN :
          (state_q == NS_Y || state_q == EW_Y) ? YEL : RED;
`ifdef PED_SHORTEN_EN
    early = tick & (state_q == NS_G) & pend_q & (sec_nx >= MIN);
`else
    early = 1'b0;
`endif
    done = (tick & (sec_nx >= dur)) | early;
    nxt = (state_q >= RED_B) ? NS_G : state_q + 3'd1;
    state_d = done ? nxt : state_q;
    pre_d = (done | tick) ? '0 : pre_q + 1'b1;
    sec_d = done ? '0 : tick ? (&sec_q ? sec_q : sec_nx[7:0]) : sec_q;
    rise = ped_btn & ~ped_q;
    enter = done & (state_q == RED_A);
    // an edge coinciding with the entry clear keeps the request, which is then served one cycle later
    svc = enter | def_q;
    def_d = enter & rise;
    pend_d = rise | (pend_q & ~svc);
    served_d = svc ? pend_q : served_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NS_G;
      pre_q <= '0;
      sec_q <= '0;
      ped_q <= 1'b1;
      pend_q <= 1'b0;
      served_q <= 1'b0;
      def_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      sec_q <= sec_d;
      ped_q <= ped_btn;
      pend_q <= pend_d;
      served_q <= served_d;
      def_q <= def_d;
    end
  end
  assign ns_light = (state_q == NS_G) ? 3'b001 : (state_q == NS_Y) ? 3'b010 : 3'b100;
  assign ew_light = (state_q == EW_G) ? 3'b001 : (state_q == EW_Y) ? 3'b010 : 3'b100;
  assign walk = served_q & (state_q == EW_G);
  assign ped_pending = pend_q;
endmodule
